// File: rtl/utlb.sv
// Micro-TLB: a small fully associative cache of 4 KB translations in front of the shared main TLB.
// It answers hits in the same cycle and refills misses through a req/ack handshake.
module utlb #(
  parameter int ENTRIES = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        lookup_valid,
  input  logic [19:0] lookup_vpn,
  input  logic [9:0]  lookup_asid,
  output logic        lookup_ready,
  output logic [19:0] pfn,
  output logic [1:0]  mat,
  output logic        pg_v,
  output logic        pg_d,
  output logic [1:0]  pg_plv,
  output logic        tlb_ne,
  input  logic        flush,
  output logic        mtlb_req,
  output logic [19:0] mtlb_vpn,
  output logic [9:0]  mtlb_asid,
  input  logic        mtlb_ack,
  input  logic        mtlb_found,
  input  logic [19:0] mtlb_pfn,
  input  logic [1:0]  mtlb_mat,
  input  logic        mtlb_v,
  input  logic        mtlb_d,
  input  logic [1:0]  mtlb_plv,
  input  logic        mtlb_g
);
  localparam int IW = $clog2(ENTRIES);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] NE   = 2'd2;

  logic [1:0]         state;
  logic               drop;
  logic [IW-1:0]      ptr;
  logic [ENTRIES-1:0] ent_vld;
  logic [ENTRIES-1:0] ent_g;
  logic [19:0]        ent_vpn  [ENTRIES];
  logic [9:0]         ent_asid [ENTRIES];
  logic [25:0]        ent_pay  [ENTRIES];
  logic               hit;
  logic [IW-1:0]      hit_idx;
  logic               fill;

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ent_vld[i] && (ent_vpn[i] == lookup_vpn) &&
          (ent_g[i] || (ent_asid[i] == lookup_asid))) begin
        hit     = 1'b1;
        hit_idx = i[IW-1:0];
      end
    end
  end

  assign fill     = (state == REQ) && mtlb_ack && !drop && mtlb_found;
  assign mtlb_req = (state == REQ);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      drop      <= 1'b0;
      ptr       <= '0;
      ent_vld   <= '0;
      mtlb_vpn  <= '0;
      mtlb_asid <= '0;
    end else begin
      // A same-cycle flush overrides the fill's valid bit.
      if (flush)
        ent_vld <= '0;
      else if (fill)
        ent_vld[ptr] <= 1'b1;
      if (fill)
        ptr <= ptr + IW'(1);
      case (state)
        IDLE: begin
          if (lookup_valid && !hit) begin
            state     <= REQ;
            mtlb_vpn  <= lookup_vpn;
            mtlb_asid <= lookup_asid;
            drop      <= 1'b0;
          end
        end
        REQ: begin
          // A flush during the refill makes the returning entry stale.
          if (flush)
            drop <= 1'b1;
          if (mtlb_ack)
            state <= (drop || mtlb_found) ? IDLE : NE;
        end
        NE:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      ent_vpn[ptr]  <= mtlb_vpn;
      ent_asid[ptr] <= mtlb_asid;
      ent_g[ptr]    <= mtlb_g;
      ent_pay[ptr]  <= {mtlb_pfn, mtlb_mat, mtlb_v, mtlb_d, mtlb_plv};
    end
  end

  always_comb begin
    lookup_ready = 1'b0;
    tlb_ne       = 1'b0;
    {pfn, mat, pg_v, pg_d, pg_plv} = '0;
    if (state == NE) begin
      lookup_ready = 1'b1;
      tlb_ne       = 1'b1;
    end else if ((state == IDLE) && lookup_valid && hit) begin
      lookup_ready = 1'b1;
      {pfn, mat, pg_v, pg_d, pg_plv} = ent_pay[hit_idx];
    end
  end
endmodule

// File: tb/tb_utlb.sv
// Bench for utlb: directed scenarios plus random lookups against an associative reference model.
module tb_utlb;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        lookup_valid = 1'b0;
  logic [19:0] lookup_vpn = '0;
  logic [9:0]  lookup_asid = '0;
  logic        lookup_ready;
  logic [19:0] pfn;
  logic [1:0]  mat;
  logic        pg_v, pg_d;
  logic [1:0]  pg_plv;
  logic        tlb_ne;
  logic        flush = 1'b0;
  logic        mtlb_req;
  logic [19:0] mtlb_vpn;
  logic [9:0]  mtlb_asid;
  logic        mtlb_ack = 1'b0;
  logic        mtlb_found = 1'b0;
  logic [19:0] mtlb_pfn = '0;
  logic [1:0]  mtlb_mat = '0;
  logic        mtlb_v = 1'b0, mtlb_d = 1'b0, mtlb_g = 1'b0;
  logic [1:0]  mtlb_plv = '0;

  int checks = 0;
  int errors = 0;

  // Reference model: entry key plus payload {pfn,mat,v,d,plv,g}
  logic        m_vld  [N];
  logic [19:0] m_vpn  [N];
  logic [9:0]  m_asid [N];
  logic [26:0] m_pay  [N];
  int          m_ptr;

  logic [27:0] obs;
  assign obs = {lookup_ready, pfn, mat, pg_v, pg_d, pg_plv, tlb_ne};

  utlb #(.ENTRIES(N)) dut (
    .clk(clk), .resetn(resetn),
    .lookup_valid(lookup_valid), .lookup_vpn(lookup_vpn), .lookup_asid(lookup_asid),
    .lookup_ready(lookup_ready), .pfn(pfn), .mat(mat), .pg_v(pg_v), .pg_d(pg_d),
    .pg_plv(pg_plv), .tlb_ne(tlb_ne), .flush(flush),
    .mtlb_req(mtlb_req), .mtlb_vpn(mtlb_vpn), .mtlb_asid(mtlb_asid),
    .mtlb_ack(mtlb_ack), .mtlb_found(mtlb_found), .mtlb_pfn(mtlb_pfn),
    .mtlb_mat(mtlb_mat), .mtlb_v(mtlb_v), .mtlb_d(mtlb_d), .mtlb_plv(mtlb_plv),
    .mtlb_g(mtlb_g)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] model_out(input logic [19:0] vpn, input logic [9:0] asid);
    for (int i = 0; i < N; i++)
      if (m_vld[i] && m_vpn[i] == vpn && (m_pay[i][0] || m_asid[i] == asid))
        return {1'b1, m_pay[i][26:1], 1'b0};
    return '0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
  endtask

  task automatic model_fill(input logic [19:0] vpn, input logic [9:0] asid, input logic [26:0] pay);
    m_vld[m_ptr] = 1'b1;
    m_vpn[m_ptr] = vpn;
    m_asid[m_ptr] = asid;
    m_pay[m_ptr] = pay;
    m_ptr = (m_ptr + 1) % N;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    lookup_valid = 1'b0; flush = 1'b0; mtlb_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    model_clear();
    m_ptr = 0;
  endtask

  task automatic drive_ack(input logic fnd, input logic [26:0] pay);
    mtlb_ack = 1'b1;
    mtlb_found = fnd;
    {mtlb_pfn, mtlb_mat, mtlb_v, mtlb_d, mtlb_plv, mtlb_g} = pay;
  endtask

  // mode 0: plain, 1: cancel lookup in the first REQ cycle, 2: flush in the ack cycle
  task automatic do_lookup(input logic [19:0] vpn, input logic [9:0] asid, input int dly,
                           input logic fnd, input logic [26:0] pay, input int mode);
    logic [27:0] exp;
    @(posedge clk); #1;
    lookup_valid = 1'b1; lookup_vpn = vpn; lookup_asid = asid;
    #1 exp = model_out(vpn, asid);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL lookup vpn=%h asid=%h got %h want %h", vpn, asid, obs, exp);
    end
    if (exp[27]) begin
      @(posedge clk); #1 lookup_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (mode == 1) lookup_valid = 1'b0;
    #1 checks++;
    if ({mtlb_req, lookup_ready, mtlb_vpn, mtlb_asid} !== {2'b10, vpn, asid}) begin
      errors++;
      $display("FAIL req_issue got req=%b rdy=%b key=%h/%h want key=%h/%h",
               mtlb_req, lookup_ready, mtlb_vpn, mtlb_asid, vpn, asid);
    end
    repeat (dly) begin
      @(posedge clk); #2 checks++;
      if ({mtlb_req, lookup_ready} !== 2'b10) begin
        errors++;
        $display("FAIL req_wait got req=%b rdy=%b want 1/0", mtlb_req, lookup_ready);
      end
    end
    drive_ack(fnd, pay);
    if (mode == 2) flush = 1'b1;
    @(posedge clk); #1;
    mtlb_ack = 1'b0; flush = 1'b0;
    if (fnd) model_fill(vpn, asid, pay);
    if (mode == 2) begin
      model_clear();
      lookup_valid = 1'b0;
    end
    #1 exp = fnd ? (lookup_valid ? model_out(vpn, asid) : 28'd0) : {1'b1, 26'd0, 1'b1};
    checks++;
    if ({mtlb_req, obs} !== {1'b0, exp}) begin
      errors++;
      $display("FAIL after_ack vpn=%h got req=%b out=%h want req=0 out=%h", vpn, mtlb_req, obs, exp);
    end
    @(posedge clk); #1 lookup_valid = 1'b0;
    #1 checks++;
    if ({mtlb_req, obs} !== 29'd0) begin
      errors++;
      $display("FAIL settle got req=%b out=%h want 0", mtlb_req, obs);
    end
  endtask

  task automatic test_reset();
    lookup_valid = 1'b1; lookup_vpn = 20'h12345; lookup_asid = 10'd5;
    #3 checks++;
    if ({obs, mtlb_req, mtlb_vpn, mtlb_asid} !== 59'd0) begin
      errors++;
      $display("FAIL reset_outputs got out=%h req=%b key=%h/%h want 0", obs, mtlb_req, mtlb_vpn, mtlb_asid);
    end
    do_reset();
  endtask

  task automatic test_basic_fill();
    do_lookup(20'h12345, 10'd5, 0, 1'b1, {20'h0ABCD, 2'd1, 1'b1, 1'b0, 2'd0, 1'b0}, 0);
    @(posedge clk); #1;
    lookup_valid = 1'b1; lookup_vpn = 20'h12345; lookup_asid = 10'd5;
    #1 checks++;
    if ({lookup_ready, pfn, mat, tlb_ne} !== {1'b1, 20'h0ABCD, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL basic_hit got rdy=%b pfn=%h mat=%0d want 1 0abcd 1", lookup_ready, pfn, mat);
    end
    @(posedge clk); #1 lookup_valid = 1'b0;
  endtask

  task automatic test_global();
    do_lookup(20'h12345, 10'd6, 1, 1'b1, {20'h0F00D, 2'd2, 1'b1, 1'b1, 2'd3, 1'b1}, 0);
    @(posedge clk); #1;
    lookup_valid = 1'b1; lookup_vpn = 20'h12345; lookup_asid = 10'd9;
    #1 checks++;
    if ({lookup_ready, pfn, pg_plv} !== {1'b1, 20'h0F00D, 2'd3}) begin
      errors++;
      $display("FAIL global_hit got rdy=%b pfn=%h plv=%0d want 1 0f00d 3", lookup_ready, pfn, pg_plv);
    end
    @(posedge clk); #1 lookup_valid = 1'b0;
  endtask

  task automatic test_evict();
    do_reset();
    for (int v = 1; v <= 5; v++)
      do_lookup(20'(v), 10'd1, 0, 1'b1, {20'(32'h100 + v), 2'd0, 1'b1, 1'b0, 2'd0, 1'b0}, 0);
    @(posedge clk); #1;
    lookup_valid = 1'b1; lookup_vpn = 20'h00002; lookup_asid = 10'd1;
    #1 checks++;
    if ({lookup_ready, pfn} !== {1'b1, 20'h00102}) begin
      errors++;
      $display("FAIL evict_keep got rdy=%b pfn=%h want 1 00102", lookup_ready, pfn);
    end
    @(posedge clk); #1 lookup_vpn = 20'h00001;
    #1 checks++;
    if (lookup_ready !== 1'b0) begin
      errors++;
      $display("FAIL evict_gone got rdy=%b want 0", lookup_ready);
    end
    lookup_valid = 1'b0;
  endtask

  task automatic test_not_found();
    do_lookup(20'h00777, 10'd2, 2, 1'b0, 27'h5A5A5A5, 0);
    do_lookup(20'h00777, 10'd2, 0, 1'b0, 27'h1234567, 1);
  endtask

  task automatic test_flush_req();
    @(posedge clk); #1;
    lookup_valid = 1'b1; lookup_vpn = 20'h00055; lookup_asid = 10'd3;
    @(posedge clk); #1 flush = 1'b1;
    model_clear();
    @(posedge clk); #1 flush = 1'b0;
    drive_ack(1'b1, {20'h0DEAD, 2'd1, 1'b1, 1'b1, 2'd0, 1'b0});
    @(posedge clk); #1 mtlb_ack = 1'b0;
    #1 checks++;
    if ({mtlb_req, lookup_ready} !== 2'b00) begin
      errors++;
      $display("FAIL flush_drop got req=%b rdy=%b want 0/0", mtlb_req, lookup_ready);
    end
    @(posedge clk); #2 checks++;
    if ({mtlb_req, mtlb_vpn} !== {1'b1, 20'h00055}) begin
      errors++;
      $display("FAIL flush_reissue got req=%b vpn=%h want 1 00055", mtlb_req, mtlb_vpn);
    end
    drive_ack(1'b1, {20'h0BEEF, 2'd1, 1'b1, 1'b1, 2'd0, 1'b0});
    @(posedge clk); #1 mtlb_ack = 1'b0;
    model_fill(20'h00055, 10'd3, {20'h0BEEF, 2'd1, 1'b1, 1'b1, 2'd0, 1'b0});
    #1 checks++;
    if (obs !== model_out(20'h00055, 10'd3)) begin
      errors++;
      $display("FAIL flush_refill got %h want %h", obs, model_out(20'h00055, 10'd3));
    end
    @(posedge clk); #1 lookup_valid = 1'b0;
    do_lookup(20'h00066, 10'd3, 0, 1'b1, {20'h00066, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1}, 2);
    do_lookup(20'h00055, 10'd3, 0, 1'b1, {20'h00055, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0}, 0);
  endtask

  task automatic test_cancel();
    do_lookup(20'h00900, 10'd4, 1, 1'b1, {20'h00900, 2'd3, 1'b0, 1'b1, 2'd1, 1'b0}, 1);
    do_lookup(20'h00900, 10'd4, 0, 1'b1, 27'd0, 0);
  endtask

  task automatic test_reset_mid();
    do_lookup(20'h0BEEF, 10'd2, 0, 1'b1, {20'h11111, 2'd1, 1'b1, 1'b0, 2'd0, 1'b0}, 0);
    @(posedge clk); #1;
    lookup_valid = 1'b1; lookup_vpn = 20'h0CAFE; lookup_asid = 10'd2;
    @(posedge clk); #3 resetn = 1'b0;
    #1 checks++;
    if ({obs, mtlb_req, mtlb_vpn, mtlb_asid} !== 59'd0) begin
      errors++;
      $display("FAIL reset_mid got out=%h req=%b key=%h/%h want 0", obs, mtlb_req, mtlb_vpn, mtlb_asid);
    end
    lookup_valid = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    model_clear();
    m_ptr = 0;
    do_lookup(20'h0BEEF, 10'd2, 0, 1'b1, {20'h22222, 2'd0, 1'b1, 1'b1, 2'd2, 1'b0}, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 250; n++) begin
      int m;
      m = ($urandom_range(0, 9) == 0) ? 2 : (($urandom_range(0, 9) == 0) ? 1 : 0);
      if ($urandom_range(0, 24) == 0) begin
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        model_clear();
      end
      do_lookup(20'($urandom_range(0, 11)), 10'($urandom_range(0, 3)), $urandom_range(0, 3),
                ($urandom_range(0, 3) != 0), 27'($urandom), m);
    end
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_global();
    test_evict();
    test_not_found();
    test_flush_req();
    test_cancel();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/utlb.md
# utlb

Micro-TLB in front of the address-translation stage: caches recent 4 KB page translations from the main TLB and supplies `pfn`, memory attribute and page flags to the translation stage in the same cycle as the lookup. On a miss it runs a request/acknowledge refill against the shared main TLB, stalls the requester until the result is available, and reports main-TLB misses (`tlb_ne`) so the pipeline can raise a refill exception. One instance per port (fetch, load/store).

## Interface
- `ENTRIES`, 4, number of fully associative entries (power of two, 2..16)
- `clk`  in  1  clock
- `resetn`  in  1  asynchronous active-low reset
- `lookup_valid`  in  1  translation request; upstream asserts only when paging applies and no DMW window hits
- `lookup_vpn`  in  20  `vaddr[31:12]`, held stable until `lookup_ready`
- `lookup_asid`  in  10  current ASID, held stable until `lookup_ready`
- `lookup_ready`  out  1  result valid this cycle
- `pfn`  out  20  physical frame number to the translation stage
- `mat`  out  2  memory access type to the translation stage
- `pg_v`, `pg_d`  out  1 each  page valid / dirty
- `pg_plv`  out  2  page privilege level
- `tlb_ne`  out  1  main TLB has no matching entry (valid only with `lookup_ready`)
- `flush`  in  1  invalidate all entries (TLBWR/TLBFILL/INVTLB/ASID write)
- `mtlb_req`  out  1  refill request to main TLB
- `mtlb_vpn`  out  20, `mtlb_asid`  out  10  latched refill key
- `mtlb_ack`  in  1  main TLB response valid
- `mtlb_found`  in  1  match found
- `mtlb_pfn`  in  20, `mtlb_mat`  in  2, `mtlb_v`  in  1, `mtlb_d`  in  1, `mtlb_plv`  in  2, `mtlb_g`  in  1  response payload, already resolved to the 4 KB frame

## Operation
- Entry: valid, vpn[19:0], asid[9:0], g, pfn, mat, v, d, plv.
- Hit: entry valid ∧ vpn == `lookup_vpn` ∧ (g ∨ asid == `lookup_asid`). Multiple hits: lowest index wins.
- FSM states: IDLE, REQ, NE.
- IDLE: `lookup_valid` ∧ hit → `lookup_ready`=1 with entry payload, `tlb_ne`=0. `lookup_valid` ∧ miss → latch vpn/asid into `mtlb_vpn`/`mtlb_asid`, clear drop flag, go REQ.
- REQ: `mtlb_req`=1, key held constant. On `mtlb_ack`:
  - drop flag clear ∧ found → write entry at round-robin pointer (pointer += 1 mod ENTRIES) → IDLE. The next-cycle lookup hits.
  - drop flag clear ∧ !found → NE, no write.
  - drop flag set → IDLE, no write. The lookup re-misses.
- NE: `lookup_ready`=1, `tlb_ne`=1, payload 0 → IDLE unconditionally.
- Entries with `mtlb_v`=0 are cached as returned; invalid-page exceptions are resolved downstream from `pg_v`.
- `flush`: clears every valid bit at the edge. If state is REQ, sets the drop flag. If state is NE, the NE response is still delivered. `flush` and a fill in the same cycle: flush wins, no entry is left valid.
- `lookup_valid` dropping during REQ (pipeline cancel): the refill still completes and fills normally; NE is still entered and shown for one cycle.
- When `lookup_ready`=0, `pfn`, `mat`, `pg_*` and `tlb_ne` are 0.

## Timing
- Reset (async, `resetn`=0): all valid bits 0, state IDLE, pointer 0, drop flag 0, `mtlb_req`=0, `lookup_ready`=0, all payload outputs 0, `mtlb_vpn`/`mtlb_asid`=0.
- Hit latency: 0 cycles (combinational from lookup inputs and entry array).
- Miss, ack in the first REQ cycle: miss detected in cycle 0, `mtlb_req` high in cycle 1, fill at the end of cycle 1, `lookup_ready` in cycle 2. Each extra ack wait adds 1 cycle.
- Main-TLB miss: `tlb_ne` pulse one cycle after ack.
- `mtlb_req` is registered state; it deasserts in the cycle after ack. Ack with `mtlb_req`=0 is ignored.
- Reset mid-REQ: request dropped immediately; no fill.

## Test plan
- Reset, then lookup vpn 0x12345 asid 5 → `mtlb_req` cycle 1; ack found pfn 0x0ABCD mat 1 g 0 in cycle 1 → cycle 2 `lookup_ready`=1, `pfn`=0x0ABCD, `mat`=1; repeat lookup → 0-cycle hit.
- Same vpn, asid 6 → miss (non-global). Refill with g=1 → later lookup with asid 9 hits that entry.
- Fill ENTRIES+1 distinct vpns 0x00001..0x00005 (ENTRIES=4) → 5th fill overwrites entry 0; lookup 0x00001 misses, 0x00002 hits.
- Ack with found=0 → exactly one cycle `lookup_ready`=1, `tlb_ne`=1, `pfn`=0; nothing cached; the retry misses again.
- `flush` while in REQ, then ack found → no fill, FSM IDLE, the held lookup re-issues `mtlb_req`. `flush` in the same cycle as a fill → all entries invalid.
- `resetn` low during a pending REQ → `mtlb_req`=0, all outputs 0; a prior hit entry misses after reset.
